// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, program-memory write port and CPU-hold status of the loader.
interface prog_loader_if #(parameter int PROG_AW = 8);
    logic               start;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               pm_we;
    logic [PROG_AW-1:0] pm_addr;
    logic [7:0]         pm_wdata;
    logic               cpu_hold;
    logic               busy;
    logic               done;
    logic               err;
    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, pm_we, pm_addr, pm_wdata, cpu_hold, busy, done, err
    );
    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, pm_we, pm_addr, pm_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: reloads program memory from a length/data/XOR-checksum byte stream while holding the CPU in reset.
module prog_loader #(
    parameter int PROG_AW  = 8,
    parameter int HOLD_CYC = 2,
    parameter int TIMEOUT  = 100000
) (
    input logic          clk,
    input logic          i_rst,
    prog_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [8:0] CAP = 9'(1 << PROG_AW);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RELEASE, ERROR} state_t;

    state_t             r_state;
    logic [PROG_AW:0]   r_cnt;
    logic [8:0]         r_len;
    logic [7:0]         r_acc;
    logic [TW-1:0]      r_timer;
    logic [HW-1:0]      r_hold;
    logic               r_rx_ready, r_pm_we, r_cpu_hold, r_busy, r_done, r_err;
    logic [PROG_AW-1:0] r_pm_addr;
    logic [7:0]         r_pm_wdata;

    logic             w_take, w_tmo;
    logic [8:0]       w_n;
    logic [PROG_AW:0] w_cnt_nx;

    // rx_ready is high exactly in LEN/DATA/CSUM, so it doubles as the "timer running" qualifier
    assign w_take   = bus.rx_valid & r_rx_ready;
    assign w_tmo    = !w_take && r_timer == TW'(TIMEOUT - 1);
    assign w_n      = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
    assign w_cnt_nx = r_cnt + (PROG_AW + 1)'(1);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_acc      <= '0;
            r_timer    <= '0;
            r_hold     <= '0;
            r_rx_ready <= 1'b0;
            r_pm_we    <= 1'b0;
            r_pm_addr  <= '0;
            r_pm_wdata <= '0;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pm_we <= 1'b0;
            r_done  <= 1'b0;
            if (r_rx_ready)
                r_timer <= w_take ? '0 : r_timer + TW'(1);
            case (r_state)
                IDLE, ERROR: if (bus.start) begin
                    r_state    <= LEN;
                    r_cpu_hold <= 1'b1;
                    r_busy     <= 1'b1;
                    r_rx_ready <= 1'b1;
                    r_err      <= 1'b0;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_timer    <= '0;
                end
                LEN: begin
                    if (w_tmo || (w_take && w_n > CAP)) begin
                        r_state <= ERROR; r_err <= 1'b1; r_rx_ready <= 1'b0; r_busy <= 1'b0;
                    end else if (w_take) begin
                        r_len   <= w_n;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tmo) begin
                        r_state <= ERROR; r_err <= 1'b1; r_rx_ready <= 1'b0; r_busy <= 1'b0;
                    end else if (w_take) begin
                        r_pm_we    <= 1'b1;
                        r_pm_addr  <= r_cnt[PROG_AW-1:0];
                        r_pm_wdata <= bus.rx_data;
                        r_acc      <= r_acc ^ bus.rx_data;
                        r_cnt      <= w_cnt_nx;
                        if (9'(w_cnt_nx) == r_len)
                            r_state <= CSUM;
                    end
                end
                CSUM: begin
                    if (w_tmo || (w_take && bus.rx_data != r_acc)) begin
                        r_state <= ERROR; r_err <= 1'b1; r_rx_ready <= 1'b0; r_busy <= 1'b0;
                    end else if (w_take) begin
                        r_state    <= RELEASE;
                        r_rx_ready <= 1'b0;
                        r_hold     <= '0;
                    end
                end
                RELEASE: begin
                    if (r_hold == HW'(HOLD_CYC - 1)) begin
                        r_state    <= IDLE;
                        r_cpu_hold <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: begin
                    r_state <= ERROR; r_err <= 1'b1; r_rx_ready <= 1'b0; r_busy <= 1'b0; r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rx_ready = r_rx_ready;
    assign bus.pm_we    = r_pm_we;
    assign bus.pm_addr  = r_pm_addr;
    assign bus.pm_wdata = r_pm_wdata;
    assign bus.cpu_hold = r_cpu_hold;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
endmodule
